// File: rtl/median_feeder_pkg.sv
// Shared types and defaults for the median filter tap feeder.
// Optional build macro: MEDIAN_FEEDER_EDGE_REPLICATE_EN (edge-replicate start of run).
package median_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_NUM_WORDS = 8533;

endpackage

// File: rtl/median_tap_delay.sv
// Circular delay line of 2*TAP_STRIDE samples with read taps at distance S and 2S.
// MEDIAN_FEEDER_EDGE_REPLICATE_EN: taps not yet filled return the first sample of the run.
module median_tap_delay #(
    parameter int WIDTH      = 32,
    parameter int TAP_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] tap_s,
    output logic [WIDTH-1:0] tap_2s,
    output logic             prime_last
);

    localparam int DEPTH = 2 * TAP_STRIDE;
    localparam int PW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] STRIDE_P  = PW'(TAP_STRIDE);
    localparam logic [PW-1:0] WP_LAST   = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp_s;
    logic [FW-1:0]    fill;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wp   <= '0;
            fill <= '0;
        end else if (push) begin
            wp <= (wp == WP_LAST) ? '0 : wp + PW'(1);
            if (fill != FILL_FULL) begin
                fill <= fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= push_data;
        end
    end

    // The 2S-old sample sits exactly at wp, about to be overwritten by this push.
    always_comb begin
        rp_s = (wp >= STRIDE_P) ? wp - STRIDE_P : wp + STRIDE_P;
    end

    assign prime_last = (fill == FILL_LAST);

`ifdef MEDIAN_FEEDER_EDGE_REPLICATE_EN
    localparam logic [FW-1:0] FILL_S = FW'(TAP_STRIDE);

    logic [WIDTH-1:0] first_q;
    logic [WIDTH-1:0] first;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= '0;
        end else if (push && fill == '0) begin
            first_q <= push_data;
        end
    end

    always_comb begin
        first  = (fill == '0) ? push_data : first_q;
        tap_s  = (fill >= FILL_S) ? mem[rp_s] : first;
        tap_2s = (fill == FILL_FULL) ? mem[wp] : first;
    end
`else
    always_comb begin
        tap_s  = mem[rp_s];
        tap_2s = mem[wp];
    end
`endif

endmodule

// File: rtl/median_tap_feeder.sv
// Turns one sample stream into aligned {x[n], x[n-S], x[n-2S]} triples for the median filter.
// MEDIAN_FEEDER_EDGE_REPLICATE_EN: skip priming, replicate the first sample into unfilled taps.
module median_tap_feeder
    import median_feeder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    parameter int TAP_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [WIDTH-1:0] in0_in_data,
    output logic [WIDTH-1:0] in1_in_data,
    output logic [WIDTH-1:0] in2_in_data,
    output logic             tap_valid,
    input  logic             tap_ready,
    output logic             done
);

    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_WORDS);

    feeder_state_t    state;
    feeder_state_t    next_state;
    logic [CW-1:0]    emit_cnt;
    logic [CW-1:0]    load_cnt;
    logic             accept;
    logic             take;
    logic             start_ok;
    logic             prime_last;
    logic [WIDTH-1:0] tap_s;
    logic [WIDTH-1:0] tap_2s;

    // pix side: accept = pix_valid & pix_ready; tap side: take = tap_valid & tap_ready.
    assign accept   = pix_valid & pix_ready;
    assign take     = tap_valid & tap_ready;
    assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));

    median_tap_delay #(
        .WIDTH      (WIDTH),
        .TAP_STRIDE (TAP_STRIDE)
    ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .push       (accept),
        .push_data  (pix_data),
        .tap_s      (tap_s),
        .tap_2s     (tap_2s),
        .prime_last (prime_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef MEDIAN_FEEDER_EDGE_REPLICATE_EN
                    next_state = ST_STREAM;
`else
                    next_state = ST_PRIME;
`endif
                end
            end
            ST_PRIME: begin
                if (accept && prime_last) begin
                    next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (take && emit_cnt == CNT_LAST) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The load cap stops the stream from taking samples beyond the last triple of the run.
    always_comb begin
        pix_ready = 1'b0;
        done      = 1'b0;
        case (state)
            ST_PRIME:  pix_ready = 1'b1;
            ST_STREAM: pix_ready = (!tap_valid || tap_ready) && (load_cnt != CNT_FULL);
            ST_DONE:   done      = 1'b1;
            default:   pix_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in0_in_data <= '0;
            in1_in_data <= '0;
            in2_in_data <= '0;
            tap_valid   <= 1'b0;
            emit_cnt    <= '0;
            load_cnt    <= '0;
        end else if (start_ok) begin
            emit_cnt <= '0;
            load_cnt <= '0;
        end else if (state == ST_STREAM) begin
            if (accept) begin
                in0_in_data <= pix_data;
                in1_in_data <= tap_s;
                in2_in_data <= tap_2s;
                tap_valid   <= 1'b1;
                load_cnt    <= load_cnt + CW'(1);
            end else if (take) begin
                tap_valid <= 1'b0;
            end
            if (take) begin
                emit_cnt <= emit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_median_tap_feeder.sv
// Bench for median_tap_feeder: four instances with different stride/run length share one stimulus bus.
module tb_median_tap_feeder;
  localparam int TW = 16;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          tap_ready = 1'b0;
  int            sel = 0;

  logic [ND-1:0] st;
  logic [ND-1:0] pr;
  logic [ND-1:0] tv;
  logic [ND-1:0] dn;
  logic [TW-1:0] o0 [ND];
  logic [TW-1:0] o1 [ND];
  logic [TW-1:0] o2 [ND];

  logic [TW-1:0]   smp [64];
  logic [3*TW-1:0] exp_q [$];
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  assign st = start ? (ND'(1) << sel) : '0;

  median_tap_feeder #(.WIDTH(TW), .NUM_WORDS(4), .TAP_STRIDE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pr[0]), .in0_in_data(o0[0]), .in1_in_data(o1[0]), .in2_in_data(o2[0]),
    .tap_valid(tv[0]), .tap_ready(tap_ready), .done(dn[0]));

  median_tap_feeder #(.WIDTH(TW), .NUM_WORDS(2), .TAP_STRIDE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pr[1]), .in0_in_data(o0[1]), .in1_in_data(o1[1]), .in2_in_data(o2[1]),
    .tap_valid(tv[1]), .tap_ready(tap_ready), .done(dn[1]));

  median_tap_feeder #(.WIDTH(TW), .NUM_WORDS(7), .TAP_STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pr[2]), .in0_in_data(o0[2]), .in1_in_data(o1[2]), .in2_in_data(o2[2]),
    .tap_valid(tv[2]), .tap_ready(tap_ready), .done(dn[2]));

  median_tap_feeder #(.WIDTH(TW), .NUM_WORDS(3), .TAP_STRIDE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pr[3]), .in0_in_data(o0[3]), .in1_in_data(o1[3]), .in2_in_data(o2[3]),
    .tap_valid(tv[3]), .tap_ready(tap_ready), .done(dn[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_seq(input int base);
    for (int i = 0; i < 64; i++) smp[i] = TW'(base + i);
  endtask

  task automatic set_rand();
    for (int i = 0; i < 64; i++) smp[i] = TW'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    tap_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      check("rst_pix_ready", 64'(pr[i]), 64'd0);
      check("rst_tap_valid", 64'(tv[i]), 64'd0);
      check("rst_done", 64'(dn[i]), 64'd0);
      check("rst_taps", 64'({o0[i], o1[i], o2[i]}), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: triple n is {x[n+2S], x[n+S], x[n]} after priming, or clamped to x[0] when replicating.
  task automatic build_model(input int nw, input int s, output int consumed);
    exp_q.delete();
    for (int n = 0; n < nw; n++) begin
`ifdef MEDIAN_FEEDER_EDGE_REPLICATE_EN
      exp_q.push_back({smp[n], (n >= s) ? smp[n - s] : smp[0], (n >= 2 * s) ? smp[n - 2 * s] : smp[0]});
`else
      exp_q.push_back({smp[n + 2 * s], smp[n + s], smp[n]});
`endif
    end
`ifdef MEDIAN_FEEDER_EDGE_REPLICATE_EN
    consumed = nw;
`else
    consumed = nw + 2 * s;
`endif
  endtask

  task automatic run_case(input int sel_i, input int nw, input int s, input bit rnd,
                          input int bp_at, input int stop_after);
    int acc;
    int took;
    int consumed;
    bit hold;
    logic [3*TW-1:0] held;
    logic [3*TW-1:0] got;
    build_model(nw, s, consumed);
    sel = sel_i;
    start = 1'b1;
    pix_valid = 1'b0;
    tap_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    took = 0;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400 && took < nw; cyc++) begin
      pix_data = smp[acc];
      pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tap_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= bp_at && cyc < bp_at + 5);
      #1;
      got = {o0[sel], o1[sel], o2[sel]};
      if (hold) begin
        check("hold_valid", 64'(tv[sel]), 64'd1);
        check("hold_taps", 64'(got), 64'(held));
      end
      if (tv[sel] && !tap_ready) check("ready_under_stall", 64'(pr[sel]), 64'd0);
      if (tv[sel] && tap_ready) begin
        if (exp_q.size() > 0) check("triple", 64'(got), 64'(exp_q.pop_front()));
        else check("extra_triple", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
        took++;
      end
      hold = tv[sel] && !tap_ready;
      held = got;
      if (pix_valid && pr[sel]) acc++;
      if (stop_after > 0 && acc >= stop_after) break;
      @(negedge clk);
    end
    if (stop_after == 0) begin
      check("taken_count", 64'(took), 64'(nw));
      pix_data = smp[acc];
      pix_valid = 1'b1;
      tap_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        check("done", 64'(dn[sel]), 64'd1);
        check("done_no_valid", 64'(tv[sel]), 64'd0);
        check("no_over_accept", 64'(pr[sel]), 64'd0);
        @(negedge clk);
      end
      check("consumed", 64'(acc), 64'(consumed));
      pix_valid = 1'b0;
      tap_ready = 1'b0;
    end
  endtask

  initial begin
    do_reset();

    set_seq(1);
    run_case(0, 4, 1, 1'b0, 1000, 0);

    set_seq(1);
    run_case(0, 4, 1, 1'b0, 3, 0);

    set_seq(10);
    run_case(1, 2, 3, 1'b0, 1000, 0);

    set_seq(7);
    run_case(3, 3, 1, 1'b0, 1000, 0);

    set_rand();
    run_case(2, 7, 2, 1'b1, 1000, 0);
    set_rand();
    run_case(2, 7, 2, 1'b1, 1000, 0);
    set_rand();
    run_case(1, 2, 3, 1'b1, 1000, 0);

    set_seq(100);
    run_case(0, 4, 1, 1'b0, 1000, 4);
    do_reset();
    set_seq(1);
    run_case(0, 4, 1, 1'b0, 1000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
